// File: rtl/char_stream_pkg.sv
// Shared types and default sizing for the character stream RAM.
// Holds the stream FSM state encoding and the memory index width helper.
package char_stream_pkg;

   localparam int DEF_WORD_SIZE  = 16;
   localparam int DEF_ADDR_WIDTH = 16;
   localparam int DEF_MEM_DEPTH  = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Narrowest index that addresses every word; never below one bit.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/char_mem.sv
// MEM_DEPTH x WORD_SIZE storage: one write port, one synchronous read port.
// A read and write to the same word in one cycle returns the old contents.
module char_mem
   import char_stream_pkg::*;
#(
   parameter  int WORD_SIZE  = DEF_WORD_SIZE,
   parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter  int MEM_DEPTH  = DEF_MEM_DEPTH,
   localparam int IW         = idx_width(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WORD_SIZE-1:0]  wr_data,
   input  logic                  rd_en,
   input  logic [IW-1:0]         rd_addr,
   output logic [WORD_SIZE-1:0]  rd_data
);

   logic [WORD_SIZE-1:0] mem [0:MEM_DEPTH-1];
   logic                 wr_ok;

   assign wr_ok = wr_en && ({1'b0, wr_addr} < (ADDR_WIDTH+1)'(MEM_DEPTH));

   // Array contents are intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_addr[IW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/char_stream_ram.sv
// Character RAM that streams a validated address window over a valid/ready port.
// Define CHAR_STREAM_LOOP_EN to repeat the window until abort or reset.
//
// state | meaning
// IDLE  | waiting for start, validates the requested window
// FETCH | synchronous read of mem[ptr] in flight
// SEND  | out_data/out_addr presented, waiting for out_ready
// DONE  | done pulse cycle, back to IDLE next
module char_stream_ram
   import char_stream_pkg::*;
#(
   parameter int WORD_SIZE  = DEF_WORD_SIZE,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WORD_SIZE-1:0]  wr_data,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] length,
   output logic [WORD_SIZE-1:0]  out_data,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int IW = idx_width(MEM_DEPTH);

   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH-1:0] remaining;
   logic [ADDR_WIDTH:0]   range_end;
   logic                  window_ok;
`ifdef CHAR_STREAM_LOOP_EN
   logic [ADDR_WIDTH-1:0] base_r;
   logic [ADDR_WIDTH-1:0] len_r;
`endif

   // One extra bit so base_addr+length cannot wrap past MEM_DEPTH.
   assign range_end = {1'b0, base_addr} + {1'b0, length};
   assign window_ok = (length != '0) && (range_end <= (ADDR_WIDTH+1)'(MEM_DEPTH));
   assign busy      = (state != IDLE);

   char_mem #(
      .WORD_SIZE (WORD_SIZE),
      .ADDR_WIDTH(ADDR_WIDTH),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_en  (state == FETCH),
      .rd_addr(ptr[IW-1:0]),
      .rd_data(out_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
         out_addr  <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
`ifdef CHAR_STREAM_LOOP_EN
         base_r    <= '0;
         len_r     <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         // Abort wins over a same-cycle handshake.
         if (abort && state != IDLE) begin
            state     <= IDLE;
            out_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (window_ok) begin
                        ptr       <= base_addr;
                        remaining <= length;
`ifdef CHAR_STREAM_LOOP_EN
                        base_r    <= base_addr;
                        len_r     <= length;
`endif
                        state     <= FETCH;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               FETCH: begin
                  out_addr  <= ptr;
                  out_valid <= 1'b1;
                  state     <= SEND;
               end
               SEND: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     if (remaining > ADDR_WIDTH'(1)) begin
                        ptr       <= ptr + ADDR_WIDTH'(1);
                        remaining <= remaining - ADDR_WIDTH'(1);
                        state     <= FETCH;
                     end else begin
                        done <= 1'b1;
`ifdef CHAR_STREAM_LOOP_EN
                        ptr       <= base_r;
                        remaining <= len_r;
                        state     <= FETCH;
`else
                        state     <= DONE;
`endif
                     end
                  end
               end
               DONE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_char_stream_ram.sv
// Directed bench for char_stream_ram with hand-computed expectations.
// Covers the looping variant when CHAR_STREAM_LOOP_EN is defined.
module tb_char_stream_ram;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        start;
   logic        abort;
   logic [15:0] base_addr;
   logic [15:0] length;
   logic [15:0] out_data;
   logic [15:0] out_addr;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic        err;

   int n_cmp  = 0;
   int n_err  = 0;
   int n_done = 0;
   int d0;

   char_stream_ram dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .start    (start),
      .abort    (abort),
      .base_addr(base_addr),
      .length   (length),
      .out_data (out_data),
      .out_addr (out_addr),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) n_done++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (out_valid !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      check({tag, " valid"}, 32'(out_valid), 32'd1);
   endtask

   task automatic launch(input int base, input int len);
      base_addr = 16'(base);
      length    = 16'(len);
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   initial begin
      string msg = "HELLO WORLD!";
      rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; abort = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #2;
      check("rst out_valid", 32'(out_valid), 0);
      check("rst out_data", 32'(out_data), 0);
      check("rst busy", 32'(busy), 0);
      check("rst done_err", {30'd0, done, err}, 0);
      step();
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         wr_en = 1'b1; wr_addr = 16'(i); wr_data = 16'(msg[i]);
         step();
      end
      wr_en = 1'b0;

`ifdef CHAR_STREAM_LOOP_EN
      launch(0, 2);
      for (int i = 0; i < 5; i++) begin
         wait_valid("loop");
         check("loop data", 32'(out_data), (i % 2 == 0) ? 32'("H") : 32'("E"));
         check("loop addr", 32'(out_addr), 32'(i % 2));
         step();
         check("loop done", 32'(done), 32'(i % 2));
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("loop abort busy", 32'(busy), 0);
      check("loop abort valid", 32'(out_valid), 0);
`else
      // Full message with a start-while-busy attempt in the middle.
      d0 = n_done;
      launch(0, 12);
      for (int i = 0; i < 12; i++) begin
         wait_valid("hello");
         check("hello data", 32'(out_data), 32'(msg[i]));
         check("hello addr", 32'(out_addr), 32'(i));
         if (i == 3) begin
            start = 1'b1; length = '0;
         end
         step();
         if (i == 3) begin
            start = 1'b0;
            check("busy start err", 32'(err), 0);
         end
      end
      check("hello done", 32'(done), 1);
      check("hello busy in done", 32'(busy), 1);
      step();
      check("hello done clear", 32'(done), 0);
      check("hello busy after", 32'(busy), 0);
      check("hello done count", 32'(n_done - d0), 1);

      // Rejected windows and the exact-fit boundary.
      launch(10, 3);
      check("range err", 32'(err), 1);
      check("range busy", 32'(busy), 0);
      step();
      check("range err clear", 32'(err), 0);
      launch(0, 0);
      check("zero len err", 32'(err), 1);
      check("zero len busy", 32'(busy), 0);
      launch(9, 3);
      check("fit err", 32'(err), 0);
      check("fit busy", 32'(busy), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("fit abort busy", 32'(busy), 0);

      // Backpressure on the first word.
      out_ready = 1'b0;
      launch(4, 3);
      wait_valid("bp");
      for (int i = 0; i < 5; i++) begin
         check("bp hold data", 32'(out_data), 32'("O"));
         check("bp hold addr", 32'(out_addr), 4);
         check("bp hold valid", 32'(out_valid), 1);
         step();
      end
      out_ready = 1'b1;
      check("bp data0", 32'(out_data), 32'("O"));
      step();
      wait_valid("bp1");
      check("bp data1", 32'(out_data), 32'(" "));
      check("bp addr1", 32'(out_addr), 5);
      step();
      wait_valid("bp2");
      check("bp data2", 32'(out_data), 32'("W"));
      check("bp addr2", 32'(out_addr), 6);
      step();
      check("bp done", 32'(done), 1);
      step();

      // Abort during the second SEND.
      launch(0, 12);
      wait_valid("ab0");
      step();
      wait_valid("ab1");
      check("ab data1", 32'(out_data), 32'("E"));
      abort = 1'b1;
      d0 = n_done;
      step();
      abort = 1'b0;
      check("abort valid", 32'(out_valid), 0);
      check("abort busy", 32'(busy), 0);
      repeat (3) step();
      check("abort no done", 32'(n_done - d0), 0);

      // Asynchronous reset mid-stream.
      launch(0, 12);
      wait_valid("rs");
      #2 rst_n = 1'b0;
      #1;
      check("async out_valid", 32'(out_valid), 0);
      check("async out_data", 32'(out_data), 0);
      check("async out_addr", 32'(out_addr), 0);
      check("async busy_done_err", {29'd0, busy, done, err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Same-cycle write during FETCH returns the old word.
      launch(1, 1);
      wr_en = 1'b1; wr_addr = 16'd1; wr_data = 16'("X");
      step();
      wr_en = 1'b0;
      check("rbw valid", 32'(out_valid), 1);
      check("rbw data", 32'(out_data), 32'("E"));
      check("rbw addr", 32'(out_addr), 1);
      step();
      step();
      launch(1, 1);
      wait_valid("rbw2");
      check("rbw new data", 32'(out_data), 32'("X"));
      step();
      step();

      // Out-of-range writes must not alias onto low words.
      wr_en = 1'b1; wr_addr = 16'd16; wr_data = 16'("Z");
      step();
      wr_addr = 16'd12;
      step();
      wr_en = 1'b0;
      launch(0, 1);
      wait_valid("drop");
      check("drop data", 32'(out_data), 32'("H"));
      step();
      step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
